// File: rtl/stream_pkg.sv
`default_nettype none
// ============================================================================
// Module      : stream_pkg
// Description : Shared types and constants for the two-input stream arbiter.
//               Holds the arbitration state encoding and the default beat
//               width.
// Revision    : 1.0 - initial release
// ============================================================================
package stream_pkg;

  localparam int DEFAULT_WIDTH = 8;

  // Arbitration state: which input, if any, owns the output for a packet.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOCK0 = 2'd1,
    ST_LOCK1 = 2'd2
  } arb_state_t;

endpackage : stream_pkg
`default_nettype wire

// File: rtl/arb2_pick.sv
`default_nettype none
// ============================================================================
// Module      : arb2_pick
// Description : Combinational two-requester round-robin picker. Grants the
//               prioritised requester when it requests, otherwise the other
//               one. Output is one-hot, or all zero when nobody requests.
// Ports       : req[1:0] - request per input
//               prio     - index of the requester that wins a tie
//               gnt[1:0] - one-hot grant
// Revision    : 1.0 - initial release
// ============================================================================
module arb2_pick (
  input  logic [1:0] req,
  input  logic       prio,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    if (req[prio]) begin
      gnt[prio] = 1'b1;
    end else if (req[~prio]) begin
      gnt[~prio] = 1'b1;
    end
  end

endmodule : arb2_pick
`default_nettype wire

// File: rtl/stream_arb2.sv
`default_nettype none
// ============================================================================
// Module      : stream_arb2
// Description : Two-input packet arbiter with a registered output stage.
//               Grants round-robin, holds a grant for a whole packet and
//               forwards the winning beat plus its source index through one
//               pipeline register (full throughput, 1-cycle latency).
// Ports       : clk, rst_n                 - clock, async active-low reset
//               inX_valid/ready/data/last  - upstream streams X = 0, 1
//               out_valid/ready/data/last  - registered downstream stream
//               out_sel                    - source of the registered beat
// Revision    : 1.0 - initial release
// ============================================================================
module stream_arb2
  import stream_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in0_valid,
  output logic             in0_ready,
  input  logic [WIDTH-1:0] in0_data,
  input  logic             in0_last,
  input  logic             in1_valid,
  output logic             in1_ready,
  input  logic [WIDTH-1:0] in1_data,
  input  logic             in1_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  output logic             out_sel
);

  arb_state_t       r_state;
  arb_state_t       w_state_nxt;
  logic             r_prio;
  logic             w_prio_nxt;
  logic [1:0]       w_pick;
  logic             w_slot_free;
  logic             w_grant0;
  logic             w_grant1;
  logic             w_acc0;
  logic             w_acc1;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_data;
  logic             r_out_last;
  logic             r_out_sel;

  arb2_pick u_pick (
    .req  ({in1_valid, in0_valid}),
    .prio (r_prio),
    .gnt  (w_pick)
  );

  // The output register can take a beat when empty or being drained now.
  assign w_slot_free = !r_out_valid | out_ready;

  // The picker only matters in IDLE; a lock ignores the other input entirely.
  assign w_grant0 = (r_state == ST_LOCK0) | ((r_state == ST_IDLE) & w_pick[0]);
  assign w_grant1 = (r_state == ST_LOCK1) | ((r_state == ST_IDLE) & w_pick[1]);

  assign w_acc0 = in0_valid & w_slot_free & w_grant0;
  assign w_acc1 = in1_valid & w_slot_free & w_grant1;

  // Readies are forced low while reset is held; the flops ignore their inputs
  // then anyway, so reset only needs to reach the ports.
  assign in0_ready = rst_n & w_slot_free & w_grant0;
  assign in1_ready = rst_n & w_slot_free & w_grant1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_prio  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_prio  <= w_prio_nxt;
    end
  end

  // A last beat always lands in IDLE, so a lock release and a new grant can
  // never share a cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_prio_nxt  = r_prio;
    if (w_acc0) begin
      w_prio_nxt  = 1'b1;
      w_state_nxt = in0_last ? ST_IDLE : ST_LOCK0;
    end else if (w_acc1) begin
      w_prio_nxt  = 1'b0;
      w_state_nxt = in1_last ? ST_IDLE : ST_LOCK1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_last  <= 1'b0;
      r_out_sel   <= 1'b0;
    end else if (w_acc0) begin
      r_out_valid <= 1'b1;
      r_out_data  <= in0_data;
      r_out_last  <= in0_last;
      r_out_sel   <= 1'b0;
    end else if (w_acc1) begin
      r_out_valid <= 1'b1;
      r_out_data  <= in1_data;
      r_out_last  <= in1_last;
      r_out_sel   <= 1'b1;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_last  = r_out_last;
  assign out_sel   = r_out_sel;

endmodule : stream_arb2
`default_nettype wire

// File: tb/tb_stream_arb2.sv
`default_nettype none
// ============================================================================
// Module      : tb_stream_arb2
// Description : Self-checking bench for stream_arb2 (WIDTH = 16). Source
//               queues feed a handshake driver; a negedge monitor runs a
//               reference arbitration model, a scoreboard of accepted beats,
//               and packet interleave / starvation checks. Directed scenario
//               tasks inspect the observed output stream.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_stream_arb2;

  localparam int W = 16;

  typedef struct packed {
    logic         sel;
    logic         last;
    logic [W-1:0] data;
  } beat_t;

  typedef struct packed {
    logic         last;
    logic [W-1:0] data;
  } src_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in0_valid, in0_ready, in0_last;
  logic         in1_valid, in1_ready, in1_last;
  logic [W-1:0] in0_data, in1_data;
  logic         out_valid, out_ready, out_last, out_sel;
  logic [W-1:0] out_data;

  int n_tests = 0;
  int n_fail  = 0;

  beat_t exp_q[$];
  beat_t obs_q[$];
  int    obs_cyc[$];
  src_t  sq0[$];
  src_t  sq1[$];

  bit   acc0 = 1'b0, acc1 = 1'b0, soak = 1'b0;
  int   cyc = 0;
  int   m_state = 0;  // 0 idle, 1 lock0, 2 lock1
  bit   m_prio = 1'b0;
  int   wait0 = 0, wait1 = 0;
  bit   open_pkt = 1'b0, open_sel = 1'b0;

  stream_arb2 #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in0_valid (in0_valid),
    .in0_ready (in0_ready),
    .in0_data  (in0_data),
    .in0_last  (in0_last),
    .in1_valid (in1_valid),
    .in1_ready (in1_ready),
    .in1_data  (in1_data),
    .in1_last  (in1_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_sel   (out_sel)
  );

  always #5 clk = ~clk;

  // Handshake driver: presents the head of each source queue, holds it until
  // accepted, pops on acceptance. In soak mode valid is randomly gapped.
  initial begin
    in0_valid = 1'b0; in0_data = '0; in0_last = 1'b0;
    in1_valid = 1'b0; in1_data = '0; in1_last = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        in0_valid = 1'b0;
        in1_valid = 1'b0;
      end else begin
        if (acc0 && sq0.size() > 0) void'(sq0.pop_front());
        if (acc1 && sq1.size() > 0) void'(sq1.pop_front());
        if (!(in0_valid && !acc0)) begin
          in0_valid = (sq0.size() > 0) && (!soak || $urandom_range(3) != 0);
          if (sq0.size() > 0) begin
            in0_data = sq0[0].data;
            in0_last = sq0[0].last;
          end
        end
        if (!(in1_valid && !acc1)) begin
          in1_valid = (sq1.size() > 0) && (!soak || $urandom_range(3) != 0);
          if (sq1.size() > 0) begin
            in1_data = sq1[0].data;
            in1_last = sq1[0].last;
          end
        end
      end
    end
  end

  // Monitor: reference model of arbitration, scoreboard, packet rules.
  always @(negedge clk) begin
    bit free, pk0, pk1, e0, e1;
    beat_t b;
    cyc++;
    if (!rst_n) begin
      exp_q.delete();
      m_state = 0; m_prio = 1'b0;
      acc0 = 1'b0; acc1 = 1'b0;
      wait0 = 0; wait1 = 0;
      open_pkt = 1'b0;
    end else begin
      free = (exp_q.size() == 0) || out_ready;
      pk0  = in0_valid && (m_prio == 1'b0 || !in1_valid);
      pk1  = in1_valid && (m_prio == 1'b1 || !in0_valid);
      e0   = free && (m_state == 1 || (m_state == 0 && pk0));
      e1   = free && (m_state == 2 || (m_state == 0 && pk1));

      n_tests++;
      if (in0_ready !== e0 || in1_ready !== e1)
        begin n_fail++; $display("FAIL model_ready cyc=%0d got=%b%b exp=%b%b", cyc, in1_ready, in0_ready, e1, e0); end
      n_tests++;
      if (out_valid !== (exp_q.size() != 0))
        begin n_fail++; $display("FAIL model_out_valid cyc=%0d got=%b exp=%b", cyc, out_valid, exp_q.size() != 0); end

      if (exp_q.size() != 0 && out_ready) begin
        b = exp_q.pop_front();
        n_tests++;
        if (out_sel !== b.sel || out_last !== b.last || out_data !== b.data)
          begin n_fail++; $display("FAIL sb_beat cyc=%0d got=%b/%b/%h exp=%b/%b/%h", cyc, out_sel, out_last, out_data, b.sel, b.last, b.data); end
        if (open_pkt) begin
          n_tests++;
          if (out_sel !== open_sel)
            begin n_fail++; $display("FAIL interleave cyc=%0d got_sel=%b exp_sel=%b", cyc, out_sel, open_sel); end
        end
        open_pkt = !out_last;
        open_sel = out_sel;
        obs_q.push_back('{sel: out_sel, last: out_last, data: out_data});
        obs_cyc.push_back(cyc);
      end

      acc0 = in0_valid && e0;
      acc1 = in1_valid && e1;
      if (acc0) begin
        exp_q.push_back('{sel: 1'b0, last: in0_last, data: in0_data});
        m_state = in0_last ? 0 : 1;
        m_prio  = 1'b1;
      end else if (acc1) begin
        exp_q.push_back('{sel: 1'b1, last: in1_last, data: in1_data});
        m_state = in1_last ? 0 : 2;
        m_prio  = 1'b0;
      end

      // A waiting input may see at most one packet of the other complete.
      if (acc0) wait0 = 0;
      else if (in0_valid && acc1 && in1_last) begin
        wait0++;
        n_tests++;
        if (wait0 > 1) begin n_fail++; $display("FAIL starve0 cyc=%0d got=%0d packets max=1", cyc, wait0); end
      end
      if (acc1) wait1 = 0;
      else if (in1_valid && acc0 && in0_last) begin
        wait1++;
        n_tests++;
        if (wait1 > 1) begin n_fail++; $display("FAIL starve1 cyc=%0d got=%0d packets max=1", cyc, wait1); end
      end
    end
  end

  task automatic test_reset();
    rst_n = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    n_tests++;
    if ({out_valid, out_data, out_last, out_sel, in0_ready, in1_ready} !== '0)
      begin n_fail++; $display("FAIL reset_outputs got=%b/%h/%b/%b/%b/%b exp=all 0", out_valid, out_data, out_last, out_sel, in0_ready, in1_ready); end
    rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      n_tests++;
      if (out_valid !== 1'b0) begin n_fail++; $display("FAIL idle_out_valid got=%b exp=0", out_valid); end
    end
  endtask

  task automatic test_contention();
    int base;
    logic [W-1:0] exp_d [4];
    exp_d[0] = 16'h00A0; exp_d[1] = 16'h00B0; exp_d[2] = 16'h00A1; exp_d[3] = 16'h00B1;
    @(posedge clk); #2;
    base = obs_q.size();
    out_ready = 1'b1;
    sq0.push_back('{last: 1'b1, data: 16'h00A0}); sq0.push_back('{last: 1'b1, data: 16'h00A1});
    sq1.push_back('{last: 1'b1, data: 16'h00B0}); sq1.push_back('{last: 1'b1, data: 16'h00B1});
    for (int i = 0; i < 30 && obs_q.size() < base + 4; i++) @(posedge clk);
    n_tests++;
    if (obs_q.size() < base + 4) begin
      n_fail++; $display("FAIL contention_timeout got=%0d beats exp=4", obs_q.size() - base);
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_tests++;
        if (obs_q[base+i].sel !== 1'(i % 2) || obs_q[base+i].data !== exp_d[i])
          begin n_fail++; $display("FAIL contention_beat%0d got=%b/%h exp=%b/%h", i, obs_q[base+i].sel, obs_q[base+i].data, 1'(i % 2), exp_d[i]); end
      end
      n_tests++;
      if (obs_cyc[base+3] - obs_cyc[base] !== 3)
        begin n_fail++; $display("FAIL contention_rate got=%0d cycles exp=3", obs_cyc[base+3] - obs_cyc[base]); end
    end
  endtask

  task automatic test_packet_lock();
    int base;
    bit saw_r1 = 1'b0;
    logic [W-1:0] exp_d [4];
    exp_d[0] = 16'h0010; exp_d[1] = 16'h0011; exp_d[2] = 16'h0012; exp_d[3] = 16'h0020;
    @(posedge clk); #2;
    base = obs_q.size();
    sq0.push_back('{last: 1'b0, data: 16'h0010});
    sq0.push_back('{last: 1'b0, data: 16'h0011});
    sq0.push_back('{last: 1'b1, data: 16'h0012});
    sq1.push_back('{last: 1'b1, data: 16'h0020});
    for (int i = 0; i < 30 && obs_q.size() < base + 4; i++) begin
      @(negedge clk);
      if (in1_ready && sq0.size() > 0) saw_r1 = 1'b1;
    end
    n_tests++;
    if (saw_r1) begin n_fail++; $display("FAIL lock_in1_ready got=1 exp=0 during in0 packet"); end
    n_tests++;
    if (obs_q.size() < base + 4) begin
      n_fail++; $display("FAIL lock_timeout got=%0d beats exp=4", obs_q.size() - base);
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_tests++;
        if (obs_q[base+i].sel !== (i == 3) || obs_q[base+i].data !== exp_d[i])
          begin n_fail++; $display("FAIL lock_beat%0d got=%b/%h exp=%b/%h", i, obs_q[base+i].sel, obs_q[base+i].data, (i == 3), exp_d[i]); end
      end
      n_tests++;
      if (obs_cyc[base+2] - obs_cyc[base] !== 2)
        begin n_fail++; $display("FAIL lock_contiguous got=%0d cycles exp=2", obs_cyc[base+2] - obs_cyc[base]); end
    end
  endtask

  task automatic test_backpressure();
    int base;
    bit ok = 1'b0;
    logic [W-1:0] hd;
    logic hl, hs;
    logic [W-1:0] exp_d [3];
    exp_d[0] = 16'h0030; exp_d[1] = 16'h0040; exp_d[2] = 16'h0031;
    @(posedge clk); #2;
    base = obs_q.size();
    out_ready = 1'b1;
    sq0.push_back('{last: 1'b1, data: 16'h0030}); sq0.push_back('{last: 1'b1, data: 16'h0031});
    sq1.push_back('{last: 1'b1, data: 16'h0040});
    for (int i = 0; i < 20 && !ok; i++) begin
      @(posedge clk); #2;
      if (out_valid) ok = 1'b1;
    end
    n_tests++;
    if (!ok) begin n_fail++; $display("FAIL bp_timeout got out_valid=0 exp=1"); end
    out_ready = 1'b0;
    hd = out_data; hl = out_last; hs = out_sel;
    repeat (4) begin
      @(negedge clk);
      n_tests++;
      if (out_valid !== 1'b1 || out_data !== hd || out_last !== hl || out_sel !== hs || in0_ready !== 1'b0 || in1_ready !== 1'b0)
        begin n_fail++; $display("FAIL bp_stable got=%b/%h/%b/%b rdy=%b%b exp=1/%h/%b/%b rdy=00", out_valid, out_data, out_last, out_sel, in1_ready, in0_ready, hd, hl, hs); end
    end
    @(posedge clk); #2;
    out_ready = 1'b1;
    repeat (10) @(posedge clk);
    n_tests++;
    if (obs_q.size() != base + 3 || exp_q.size() != 0) begin
      n_fail++; $display("FAIL bp_count got=%0d beats exp=3", obs_q.size() - base);
    end else begin
      for (int i = 0; i < 3; i++) begin
        n_tests++;
        if (obs_q[base+i].data !== exp_d[i])
          begin n_fail++; $display("FAIL bp_beat%0d got=%h exp=%h", i, obs_q[base+i].data, exp_d[i]); end
      end
    end
  endtask

  task automatic test_reset_mid();
    int base;
    @(posedge clk); #2;
    base = obs_q.size();
    out_ready = 1'b1;
    sq1.push_back('{last: 1'b0, data: 16'h0050});
    sq1.push_back('{last: 1'b0, data: 16'h0051});
    sq1.push_back('{last: 1'b0, data: 16'h0052});
    sq1.push_back('{last: 1'b1, data: 16'h0053});
    for (int i = 0; i < 20 && obs_q.size() < base + 2; i++) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (out_valid !== 1'b0 || in0_ready !== 1'b0 || in1_ready !== 1'b0)
      begin n_fail++; $display("FAIL midreset_outputs got=%b rdy=%b%b exp=0 rdy=00", out_valid, in1_ready, in0_ready); end
    sq0.delete(); sq1.delete();
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    base = obs_q.size();
    sq0.push_back('{last: 1'b1, data: 16'h0060});
    sq1.push_back('{last: 1'b1, data: 16'h0070});
    for (int i = 0; i < 20 && obs_q.size() < base + 2; i++) @(posedge clk);
    n_tests++;
    if (obs_q.size() < base + 2) begin
      n_fail++; $display("FAIL midreset_timeout got=%0d beats exp=2", obs_q.size() - base);
    end else begin
      n_tests++;
      if (obs_q[base].sel !== 1'b0 || obs_q[base].data !== 16'h0060 || obs_q[base+1].data !== 16'h0070)
        begin n_fail++; $display("FAIL midreset_prio got=%b/%h,%h exp=0/0060,0070", obs_q[base].sel, obs_q[base].data, obs_q[base+1].data); end
    end
  endtask

  task automatic test_soak();
    int seq0 = 0, seq1 = 0, len;
    soak = 1'b1;
    for (int c = 0; c < 10000; c++) begin
      @(posedge clk); #2;
      out_ready = ($urandom_range(3) != 0);
      if (sq0.size() < 3) begin
        len = $urandom_range(1, 4);
        for (int k = 0; k < len; k++) begin
          sq0.push_back('{last: (k == len - 1), data: W'(seq0)});
          seq0++;
        end
      end
      if (sq1.size() < 3) begin
        len = $urandom_range(1, 4);
        for (int k = 0; k < len; k++) begin
          sq1.push_back('{last: (k == len - 1), data: W'(seq1) | 16'h8000});
          seq1++;
        end
      end
    end
    soak = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 200 && (sq0.size() + sq1.size() + exp_q.size()) != 0; i++) @(posedge clk);
    n_tests++;
    if ((sq0.size() + sq1.size() + exp_q.size()) != 0)
      begin n_fail++; $display("FAIL soak_drain got=%0d pending exp=0", sq0.size() + sq1.size() + exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_contention();
    test_packet_lock();
    test_backpressure();
    test_reset_mid();
    test_soak();
    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_stream_arb2
`default_nettype wire
